memory_request_scheduler: RTL
=============================

# memory_request_scheduler

Front-end stage of the memory controller, sitting directly upstream of the `memory_bank` array. It accepts read and write requests on a valid/ready port and buffers them in a small FIFO. Each request is decoded to one bank and driven onto the shared bank bus for exactly one cycle. The bank's registered read data is then returned on a valid/ready response port.

## Interface
Parameters:
- NUM_BANKS, 4, number of banks driven; BANK_BITS = $clog2(NUM_BANKS)
- ADDR_WIDTH, 8, per-bank row address width
- DATA_WIDTH, 64, data width
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_write  in  1  1 = write, 0 = read
- req_addr  in  BANK_BITS+ADDR_WIDTH  bank index in MSBs, row in LSBs
- req_wdata  in  DATA_WIDTH  write data
- bank_sel  out  NUM_BANKS  one-hot bank select
- bank_addr  out  ADDR_WIDTH  row address to all banks
- bank_wdata  out  DATA_WIDTH  write data to all banks; 0 encodes a read
- bank_rdata  in  NUM_BANKS*DATA_WIDTH  concatenated bank rdata, bank 0 in LSBs
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  DATA_WIDTH  bank data: read result, or pre-write contents for a write
- rsp_write  out  1  echo of req_write
- rsp_err  out  1  request rejected, no bank access
- err_count  out  16  saturating count of rejected requests

## Operation
- Accept: req_valid && req_ready pushes {write, addr, wdata} into the FIFO. req_ready = !full, with no pass-through when full.
- FSM states are IDLE, ISSUE, WAIT and RESP.
- IDLE: when the FIFO is non-empty, pop the head and latch it.
  - Go to ISSUE if the request is legal.
  - Otherwise go to RESP with rsp_err=1 and rsp_rdata=0.
- A request is illegal in either of two cases:
  - It is a write with wdata==0. Banks treat zero wdata as a read, so a zero write cannot be expressed.
  - Its bank index is ≥ NUM_BANKS.
- ISSUE (one cycle): drive the following, then go to WAIT.
  - bank_sel = 1<<bank.
  - bank_addr = row.
  - bank_wdata = wdata for a write, 0 for a read.
- WAIT (one cycle): bank_sel=0. Capture the selected bank's rdata slice into rsp_rdata, then go to RESP.
- RESP: rsp_valid=1; hold all rsp_* stable until rsp_ready.
  - On handshake, pop the next entry and go directly to ISSUE if the FIFO is non-empty and the head is legal.
  - Go back to RESP (err) if the head is illegal.
  - Go to IDLE if the FIFO is empty.
- When idle, bank_sel, bank_addr and bank_wdata are all 0.
- err_count increments on entry to RESP with rsp_err=1 and saturates at 16'hFFFF.
- Responses are returned strictly in request order.

## Timing
- Reset (async, rst_n low) forces the following; all in-flight and queued requests are discarded:
  - FIFO empty and FSM in IDLE.
  - bank_sel, bank_addr, bank_wdata = 0.
  - rsp_valid, rsp_rdata, rsp_write, rsp_err = 0.
  - err_count = 0.
  - req_ready = 1.
- Legal request accepted at edge N into an empty FIFO with the FSM idle:
  - bank_sel is high from N+1 to N+2.
  - The bank registers rdata at N+2.
  - rsp_valid rises at N+3.
- Illegal request accepted at edge N: rsp_valid rises at N+2 and no bank_sel pulse occurs.
- Back-to-back legal requests with rsp_ready held at 1 complete one per 3 cycles.
- bank_sel is never high for two consecutive cycles.
- Push and pop on the same edge are both honoured and the count is unchanged. When full, the push is blocked because req_ready=0.
- FIFO pointers wrap modulo FIFO_DEPTH. full and empty are derived from a count of width $clog2(FIFO_DEPTH)+1.
- rsp_ready low stalls the FSM in RESP while the FIFO keeps accepting until full.
- Reset asserted mid-ISSUE: bank_sel drops asynchronously and the bank's write is not guaranteed; the bench must not check that row.

## Structure
- Shared package memory_ctrl_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - a mem_req_t struct {write, addr, wdata}
  - the error-counter width constant
- Sub-module mem_req_fifo: parameterised synchronous FIFO of mem_req_t with push/pop/full/empty and async active-low reset.

## Test plan
- Write 10'h1A5 with data 64'hDEADBEEF into empty memory, then read 10'h1A5:
  - Write drives bank_sel=4'b0010, bank_addr=8'hA5, bank_wdata=64'hDEADBEEF for one cycle; its response is rsp_write=1, rsp_err=0.
  - Read drives bank_wdata=0 and returns rsp_rdata=64'hDEADBEEF at N+3.
- Write 10'h020 with data 0: rsp_err=1, rsp_rdata=0, no bank_sel pulse, err_count=1.
- Push 5 reads with FIFO_DEPTH=4 and rsp_ready=0:
  - Exactly 5 are accepted: 1 in flight and 4 queued, after which req_ready=0.
  - Raising rsp_ready drains 5 in-order responses, one per 3 cycles.
- Reads to banks 0,1,2,3 at row 8'h10, with bank_rdata slices preloaded as 'h0A,'h0B,'h0C,'h0D: rsp_rdata is 'h0A,'h0B,'h0C,'h0D in order.
- Assert rst_n low for one cycle while 3 requests are queued and one is in RESP:
  - All outputs go to their reset values immediately.
  - No stale response appears afterwards.
  - A fresh read completes with N+3 latency.
- Write 10'h0FF with data 'h1, then write the same address with data 'h2: the second response carries rsp_rdata='h1, the pre-write contents.

Source files
------------

// File: rtl/memory_ctrl_pkg.sv
// Shared types and constants for the memory controller front end.
// mem_req_t describes a request at the default controller geometry.
package memory_ctrl_pkg;

    localparam int unsigned ERR_COUNT_WIDTH    = 16;
    localparam int unsigned DEF_REQ_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH     = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } sched_state_e;

    typedef struct packed {
        logic                          write;
        logic [DEF_REQ_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Show-ahead synchronous request FIFO with asynchronous active-low reset.
// The head entry is visible on rdata whenever empty is low.
module mem_req_fifo
    import memory_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = mem_req_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t wdata,
    output logic   full,
    input  logic   pop,
    output entry_t rdata,
    output logic   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/memory_request_scheduler.sv
// Request scheduler: queues requests, issues each to one bank for a single cycle
// and returns the bank's registered data in request order.
module memory_request_scheduler
    import memory_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic                                 req_write,
    input  logic [$clog2(NUM_BANKS)+ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]                req_wdata,
    output logic [NUM_BANKS-1:0]                 bank_sel,
    output logic [ADDR_WIDTH-1:0]                bank_addr,
    output logic [DATA_WIDTH-1:0]                bank_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]      bank_rdata,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [DATA_WIDTH-1:0]                rsp_rdata,
    output logic                                 rsp_write,
    output logic                                 rsp_err,
    output logic [ERR_COUNT_WIDTH-1:0]           err_count
);

    localparam int unsigned BANK_BITS      = $clog2(NUM_BANKS);
    localparam int unsigned REQ_ADDR_WIDTH = BANK_BITS + ADDR_WIDTH;

    typedef struct packed {
        logic                      write;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]     wdata;
    } req_t;

    req_t                  push_req;
    req_t                  head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [BANK_BITS-1:0]  head_bank;
    logic [ADDR_WIDTH-1:0] head_row;
    logic [NUM_BANKS-1:0]  head_sel;
    logic                  head_illegal;
    sched_state_e          head_next;

    sched_state_e          state_q;
    logic [BANK_BITS-1:0]  cur_bank_q;
    logic                  cur_write_q;
    logic                  cur_err_q;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};

    mem_req_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_req),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty)
    );

    always_comb begin
        head_bank    = head.addr[REQ_ADDR_WIDTH-1:ADDR_WIDTH];
        head_row     = head.addr[ADDR_WIDTH-1:0];
        head_sel     = {{(NUM_BANKS-1){1'b0}}, 1'b1} << head_bank;
        // Banks read a zero write as a read, so zero-data writes are rejected.
        head_illegal = (head.write && (head.wdata == '0)) || (32'(head_bank) >= NUM_BANKS);
        // Rejected requests skip the bank cycle but still pass through StWait.
        head_next    = head_illegal ? StWait : StIssue;
        pop          = !fifo_empty &&
                       ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_bank_q  <= '0;
            cur_write_q <= 1'b0;
            cur_err_q   <= 1'b0;
            bank_sel    <= '0;
            bank_addr   <= '0;
            bank_wdata  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_write   <= 1'b0;
            rsp_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) state_q <= head_next;
                end
                StIssue: begin
                    bank_sel   <= '0;
                    bank_addr  <= '0;
                    bank_wdata <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    rsp_valid <= 1'b1;
                    rsp_write <= cur_write_q;
                    rsp_err   <= cur_err_q;
                    rsp_rdata <= cur_err_q ? '0
                                           : bank_rdata[cur_bank_q*DATA_WIDTH +: DATA_WIDTH];
                    if (cur_err_q && (err_count != '1)) err_count <= err_count + 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= fifo_empty ? StIdle : head_next;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (pop) begin
                cur_bank_q  <= head_bank;
                cur_write_q <= head.write;
                cur_err_q   <= head_illegal;
                if (!head_illegal) begin
                    bank_sel   <= head_sel;
                    bank_addr  <= head_row;
                    bank_wdata <= head.write ? head.wdata : '0;
                end
            end
        end
    end

endmodule
